// File: rtl/pwm_demod_pkg.sv
// Shared constants and types for the pulse-width frame demodulator.
package pwm_demod_pkg;
    localparam logic [1:0] CTG_NONE   = 2'b00;
    localparam logic [1:0] CTG_ACK    = 2'b01;
    localparam logic [1:0] CTG_FLAG   = 2'b10;
    localparam logic [1:0] CTG_SCHEME = 2'b11;

    localparam int HDR_W = 2;
    localparam int PAR_W = 1;

    typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_DELIM} sym_e;
endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider; tick is high for one clock every DIV clocks.
module sample_tick_gen #(
    parameter int DIV = 50
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/pwm_frame_demod.sv
// Classifies sampled high-pulse widths into bits/delimiters and assembles
// ACK, FLAG and SCHEME frames with header, length and even-parity checks.
module pwm_frame_demod
    import pwm_demod_pkg::*;
#(
    parameter int DIV        = 50,
    parameter int CNT_W      = 10,
    parameter int ZERO_MIN   = 0,
    parameter int ZERO_MAX   = 3,
    parameter int ONE_MIN    = 4,
    parameter int ONE_MAX    = 6,
    parameter int IDLE_TICKS = 500,
    parameter int FLAG_W     = 8,
    parameter int SCHEME_W   = 48
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                insig,
    input  logic                working,
    output logic [1:0]          ord,
    output logic [1:0]          ctg,
    output logic [FLAG_W-1:0]   cur_flag,
    output logic [SCHEME_W-1:0] cur_scheme,
    output logic                frame_valid,
    output logic                frame_err,
    output logic [7:0]          err_count
);
    localparam int BUF_W = SCHEME_W + HDR_W + PAR_W;
    localparam int LEN_W = $clog2(BUF_W + 1);
    localparam logic [LEN_W-1:0] LEN_ACK  = LEN_W'(HDR_W + PAR_W);
    localparam logic [LEN_W-1:0] LEN_FLAG = LEN_W'(FLAG_W + HDR_W + PAR_W);
    localparam logic [LEN_W-1:0] LEN_SCH  = LEN_W'(BUF_W);
    localparam logic [CNT_W-1:0] W_ZMIN   = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] W_ZMAX   = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] W_OMIN   = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] W_OMAX   = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(IDLE_TICKS - 1);

    logic             s_meta, s, tick;
    logic [BUF_W-1:0] shreg;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] width, gap, width_inc, gap_inc;
    logic             par, ovf, acc;
    logic [1:0]       acc_ctg;
    sym_e             sym;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign width_inc = (&width) ? width : width + 1'b1;
    assign gap_inc   = (&gap)   ? gap   : gap + 1'b1;

    always_comb begin
        sym = SYM_DELIM;
        if (width > W_ZMIN && width < W_ZMAX)      sym = SYM_ZERO;
        else if (width > W_OMIN && width < W_OMAX) sym = SYM_ONE;
    end

    // Header sits just above the parity bit, so its position depends on length.
    always_comb begin
        acc_ctg = CTG_NONE;
        if (len == LEN_ACK && shreg[PAR_W +: HDR_W] == CTG_ACK)
            acc_ctg = CTG_ACK;
        else if (len == LEN_FLAG && shreg[FLAG_W+PAR_W +: HDR_W] == CTG_FLAG)
            acc_ctg = CTG_FLAG;
        else if (len == LEN_SCH && shreg[SCHEME_W+PAR_W +: HDR_W] == CTG_SCHEME)
            acc_ctg = CTG_SCHEME;
        acc = (acc_ctg != CTG_NONE) && !par && !ovf;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_meta      <= 1'b0;
            s           <= 1'b0;
            shreg       <= '0;
            len         <= '0;
            width       <= '0;
            gap         <= '0;
            par         <= 1'b0;
            ovf         <= 1'b0;
            ord         <= '0;
            ctg         <= CTG_NONE;
            cur_flag    <= '0;
            cur_scheme  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            s_meta      <= insig;
            s           <= s_meta;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (tick) begin
                if (working) begin
                    shreg <= '0;
                    len   <= '0;
                    width <= '0;
                    gap   <= '0;
                    par   <= 1'b0;
                    ovf   <= 1'b0;
                end else if (s) begin
                    width <= width_inc;
                    gap   <= '0;
                end else if (width != '0) begin
                    width <= '0;
                    if (sym == SYM_DELIM) begin
                        shreg <= '0;
                        len   <= '0;
                        par   <= 1'b0;
                        ovf   <= 1'b0;
                        if (len != '0) begin
                            if (acc) begin
                                ord         <= ord + 1'b1;
                                ctg         <= acc_ctg;
                                frame_valid <= 1'b1;
                                if (acc_ctg == CTG_FLAG)   cur_flag   <= shreg[PAR_W +: FLAG_W];
                                if (acc_ctg == CTG_SCHEME) cur_scheme <= shreg[PAR_W +: SCHEME_W];
                            end else begin
                                frame_err <= 1'b1;
                                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                            end
                        end
                    end else begin
                        if (sym == SYM_ONE) par <= ~par;
                        if (len == LEN_SCH) begin
                            ovf <= 1'b1;
                        end else begin
                            shreg <= {shreg[BUF_W-2:0], sym == SYM_ONE};
                            len   <= len + 1'b1;
                        end
                    end
                end else begin
                    gap <= gap_inc;
                    // Fires once as the gap crosses the threshold, then gap just saturates.
                    if (gap == GAP_LAST) begin
                        shreg <= '0;
                        len   <= '0;
                        par   <= 1'b0;
                        ovf   <= 1'b0;
                        if (len != '0) begin
                            frame_err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_frame_demod.sv
// Self-checking bench: fixed frame table, corner sequences and random frames
// checked against a bit-list model of the frame acceptance rules.
module tb_pwm_frame_demod;
    import pwm_demod_pkg::*;

    localparam int DIV  = 4;
    localparam int IDLE = 500;

    logic        clock = 1'b0, reset = 1'b0, insig = 1'b0, working = 1'b0;
    logic [1:0]  ord, ctg;
    logic [7:0]  cur_flag, err_count;
    logic [47:0] cur_scheme;
    logic        frame_valid, frame_err;

    always #5 clock = ~clock;

    pwm_frame_demod #(.DIV(DIV), .IDLE_TICKS(IDLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .insig       (insig),
        .working     (working),
        .ord         (ord),
        .ctg         (ctg),
        .cur_flag    (cur_flag),
        .cur_scheme  (cur_scheme),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    int checks = 0, failures = 0;
    int nv = 0, ne = 0, nboth = 0;
    int e_valid = 0, e_err = 0;
    logic [1:0]  e_ord = 2'd0, e_ctg = 2'd0;
    logic [7:0]  e_flag = 8'd0, e_cnt = 8'd0;
    logic [47:0] e_scheme = 48'd0;

    always @(negedge clock) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
        if (frame_valid && frame_err) nboth++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reject();
        e_err++;
        if (e_cnt != 8'hFF) e_cnt++;
    endtask

    // Frame judged from the list of bits as sent (first bit = pat[n-1]).
    task automatic model_eval(input logic [63:0] pat, input int n);
        int ones;
        logic [1:0] hdr;
        if (n == 0) return;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(pat[i]);
        hdr = 2'b00;
        if (n >= 2) hdr = pat[n-1 -: 2];
        if (ones % 2 == 0 && ((n == 3 && hdr == CTG_ACK) || (n == 11 && hdr == CTG_FLAG) ||
                              (n == 51 && hdr == CTG_SCHEME))) begin
            e_valid++;
            e_ord++;
            e_ctg = hdr;
            if (hdr == CTG_FLAG)   e_flag   = pat[8:1];
            if (hdr == CTG_SCHEME) e_scheme = pat[48:1];
        end else begin
            model_reject();
        end
    endtask

    task automatic level(input logic v, input int n);
        insig = v;
        repeat (n * DIV) @(negedge clock);
    endtask

    task automatic pulse(input int w, input int lo);
        level(1'b1, w);
        level(1'b0, lo);
    endtask

    task automatic send_bits(input logic [63:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (pat[i]) pulse(5, int'($urandom_range(1, 3)));
            else        pulse(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)));
        end
    endtask

    task automatic send_frame(input logic [63:0] pat, input int n, input int dw);
        send_bits(pat, n);
        pulse(dw, 3);
        model_eval(pat, n);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/valid_cnt"}, 64'(nv), 64'(e_valid));
        chk({tag, "/err_cnt"}, 64'(ne), 64'(e_err));
        chk({tag, "/both"}, 64'(nboth), 64'd0);
        chk({tag, "/ord"}, 64'(ord), 64'(e_ord));
        chk({tag, "/ctg"}, 64'(ctg), 64'(e_ctg));
        chk({tag, "/cur_flag"}, 64'(cur_flag), 64'(e_flag));
        chk({tag, "/cur_scheme"}, 64'(cur_scheme), 64'(e_scheme));
        chk({tag, "/err_count"}, 64'(err_count), 64'(e_cnt));
    endtask

    typedef struct {
        logic [63:0] pat;
        int          n;
        logic        exp_ok;
        logic [1:0]  exp_ctg;
    } vec_t;

    vec_t tbl[9];
    logic [63:0] pat;
    logic [7:0]  p8;
    logic [47:0] p48;
    int n, kind, d, dw, nv0, ne0;

    initial begin
        tbl[0] = '{64'b011, 3, 1'b1, CTG_ACK};
        tbl[1] = '{64'b10_10100101_1, 11, 1'b1, CTG_FLAG};
        tbl[2] = '{64'b10_10100101_0, 11, 1'b0, CTG_NONE};
        tbl[3] = '{64'({2'b11, 48'h0123456789AB, 1'b0}), 51, 1'b1, CTG_SCHEME};
        tbl[4] = '{64'b011, 3, 1'b1, CTG_ACK};
        tbl[5] = '{64'b101, 3, 1'b0, CTG_NONE};
        tbl[6] = '{64'b11, 2, 1'b0, CTG_NONE};
        tbl[7] = '{64'({2'b11, 48'h0123456789AB, 1'b0, 4'b0000}), 55, 1'b0, CTG_NONE};
        tbl[8] = '{64'b11_00000000_0, 11, 1'b0, CTG_NONE};

        repeat (3) @(negedge clock);
        check_all("reset");
        chk("reset/frame_valid", 64'(frame_valid), 64'd0);
        chk("reset/frame_err", 64'(frame_err), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        for (int t = 0; t < 9; t++) begin
            nv0 = nv;
            ne0 = ne;
            send_frame(tbl[t].pat, tbl[t].n, 8);
            chk($sformatf("tbl%0d/valid", t), 64'(nv - nv0), 64'(tbl[t].exp_ok));
            chk($sformatf("tbl%0d/err", t), 64'(ne - ne0), 64'(!tbl[t].exp_ok));
            if (tbl[t].exp_ok) chk($sformatf("tbl%0d/ctg", t), 64'(ctg), 64'(tbl[t].exp_ctg));
            check_all($sformatf("tbl%0d", t));
        end
        chk("flag_a5", 64'(cur_flag), 64'hA5);
        chk("scheme_val", 64'(cur_scheme), 64'h0123456789AB);
        chk("ord_wrap", 64'(ord), 64'd0);

        // Partial frame abandoned by a long idle gap, then a clean ACK.
        send_bits(64'b1011, 4);
        level(1'b0, IDLE + 5);
        model_reject();
        check_all("idle");
        send_frame(64'b011, 3, 8);
        check_all("idle_ack");

        // Transmitter busy mid-FLAG wipes the partial frame and swallows a pulse.
        send_bits(64'b10101, 5);
        working = 1'b1;
        pulse(5, 2);
        working = 1'b0;
        level(1'b0, 2);
        send_frame(64'b011, 3, 8);
        check_all("working");

        for (int r = 0; r < 30; r++) begin
            kind = int'($urandom_range(0, 4));
            p8   = 8'($urandom());
            p48  = 48'({$urandom(), $urandom()});
            d    = int'($urandom_range(0, 6));
            dw   = (d < 2) ? d + 3 : d + 4;
            case (kind % 3)
                0: begin pat = 64'b011; n = 3; end
                1: begin pat = 64'({2'b10, p8, ~^p8}); n = 11; end
                default: begin pat = 64'({2'b11, p48, ^p48}); n = 51; end
            endcase
            if (kind == 3) pat = pat ^ (64'd1 << $urandom_range(0, n - 1));
            if (kind == 4) begin
                n   = int'($urandom_range(1, 12));
                pat = 64'(p48) & ((64'd1 << n) - 64'd1);
            end
            send_frame(pat, n, dw);
            check_all($sformatf("rand%0d", r));
        end

        for (int k = 0; k < 256; k++) send_frame(64'b0, 1, 8);
        check_all("sat");
        chk("sat/err_count_255", 64'(err_count), 64'd255);

        // Async reset in the middle of a frame.
        send_bits(64'b011, 3);
        #2 reset = 1'b0;
        #1;
        chk("arst/ord", 64'(ord), 64'd0);
        chk("arst/ctg", 64'(ctg), 64'd0);
        chk("arst/cur_flag", 64'(cur_flag), 64'd0);
        chk("arst/cur_scheme", 64'(cur_scheme), 64'd0);
        chk("arst/err_count", 64'(err_count), 64'd0);
        chk("arst/strobes", 64'({frame_valid, frame_err}), 64'd0);
        e_ord = 2'd0; e_ctg = 2'd0; e_flag = 8'd0; e_scheme = 48'd0; e_cnt = 8'd0;
        insig = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        send_frame(64'b011, 3, 8);
        check_all("post_reset");
        chk("post_reset/ord1", 64'(ord), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
